// File: rtl/round_pkg.sv
// Shared types and width helpers for the door-guessing round sequencer.
package round_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    JUDGE     = 3'd2,
    PAUSE     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  // Fibonacci feedback taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic int sec_w(input int round_secs, input int pause_secs);
    int m;
    m = (round_secs > pause_secs) ? round_secs : pause_secs;
    return $clog2(m + 1);
  endfunction

  function automatic int life_w(input int lives_init);
    return $clog2(lives_init + 1);
  endfunction

  function automatic int win_w(input int num_players);
    return (num_players > 2) ? $clog2(num_players) : 1;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: pulses tick on the last count, freezes under hold.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic tick
);
  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  assign tick = !hold && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (!hold)  cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/round_controller.sv
// Round sequencer: timed play, one-cycle judge, timed pause, repeat until
// at most one player survives.
module round_controller
  import round_pkg::*;
#(
  parameter int          NUM_PLAYERS   = 2,
  parameter int          NUM_DOORS     = 4,
  parameter int          LIVES_INIT    = 3,
  parameter int          TICKS_PER_SEC = 25_000_000,
  parameter int          ROUND_SECS    = 10,
  parameter int          PAUSE_SECS    = 1,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5,
  localparam int         DOOR_W        = $clog2(NUM_DOORS),
  localparam int         LIFE_W        = life_w(LIVES_INIT),
  localparam int         SEC_W         = sec_w(ROUND_SECS, PAUSE_SECS),
  localparam int         WIN_W         = win_w(NUM_PLAYERS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          hold,
  input  logic [NUM_PLAYERS*DOOR_W-1:0] player_pos,
  output state_t                        state,
  output logic [SEC_W-1:0]              seconds_left,
  output logic                          time_up,
  output logic [DOOR_W-1:0]             correct_door,
  output logic [NUM_PLAYERS*LIFE_W-1:0] lives,
  output logic [NUM_PLAYERS-1:0]        alive,
  output logic [7:0]                    round_count,
  output logic                          game_over,
  output logic [WIN_W-1:0]              winner,
  output logic                          winner_valid
);
  localparam int CNT_W = $clog2(NUM_PLAYERS + 1);
  localparam logic [NUM_PLAYERS-1:0][LIFE_W-1:0] LV_INIT =
    {NUM_PLAYERS{LIFE_W'(LIVES_INIT)}};

  state_t                               st, st_n;
  logic [SEC_W-1:0]                     secs, secs_n;
  logic [DOOR_W-1:0]                    door, door_n;
  logic [NUM_PLAYERS-1:0][LIFE_W-1:0]   lv, lv_n;
  logic [NUM_PLAYERS-1:0][DOOR_W-1:0]   pos;
  logic [7:0]                           rc, rc_n, lfsr;
  logic [CNT_W-1:0]                     alive_cnt;
  logic [WIN_W-1:0]                     win_idx;
  logic                                 clr, tick;

  sec_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
    .clk(clk), .reset(reset), .clear(clr), .hold(hold), .tick(tick)
  );

  assign pos = player_pos;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_alive
    assign alive[g] = |lv[g];
  end

  always_comb begin
    alive_cnt = '0;
    win_idx   = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      alive_cnt = alive_cnt + CNT_W'(alive[i]);
      if (alive[i]) win_idx = WIN_W'(i);
    end
  end

  // LFSR free-runs regardless of state or hold so door choice depends on timing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st   <= IDLE;
      secs <= '0;
      door <= '0;
      lv   <= LV_INIT;
      rc   <= '0;
    end else begin
      st   <= st_n;
      secs <= secs_n;
      door <= door_n;
      lv   <= lv_n;
      rc   <= rc_n;
    end
  end

  always_comb begin
    st_n   = st;
    secs_n = secs;
    door_n = door;
    lv_n   = lv;
    rc_n   = rc;
    clr    = 1'b0;
    case (st)
      IDLE, GAME_OVER: begin
        if (start) begin
          st_n   = PLAY;
          clr    = 1'b1;
          secs_n = SEC_W'(ROUND_SECS);
          door_n = lfsr[DOOR_W-1:0];
          lv_n   = LV_INIT;
          rc_n   = '0;
        end
      end
      PLAY: begin
        if (tick) begin
          if (secs == SEC_W'(1)) begin
            st_n   = JUDGE;
            secs_n = '0;
          end else begin
            secs_n = secs - 1'b1;
          end
        end
      end
      JUDGE: begin
        for (int i = 0; i < NUM_PLAYERS; i++)
          if (alive[i] && pos[i] != door) lv_n[i] = lv[i] - 1'b1;
        if (rc != 8'hFF) rc_n = rc + 8'd1;
        st_n   = PAUSE;
        secs_n = SEC_W'(PAUSE_SECS);
        clr    = 1'b1;
      end
      PAUSE: begin
        if (tick) begin
          if (secs == SEC_W'(1)) begin
            secs_n = '0;
            if (alive_cnt >= CNT_W'(2)) begin
              st_n   = PLAY;
              clr    = 1'b1;
              secs_n = SEC_W'(ROUND_SECS);
              door_n = lfsr[DOOR_W-1:0];
            end else begin
              st_n = GAME_OVER;
            end
          end else begin
            secs_n = secs - 1'b1;
          end
        end
      end
      default: st_n = IDLE;
    endcase
  end

  assign state        = st;
  assign seconds_left = secs;
  assign time_up      = (st == JUDGE) || (st == PAUSE);
  assign correct_door = door;
  assign lives        = lv;
  assign round_count  = rc;
  assign game_over    = (st == GAME_OVER);
  assign winner_valid = (st == GAME_OVER) && (alive_cnt == CNT_W'(1));
  assign winner       = winner_valid ? win_idx : '0;
endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: directed vector table, hand sequences for hold,
// late player_pos change and async reset, then randomized run vs a phase model.
module tb_round_controller;
  import round_pkg::*;

  localparam int T  = 4;
  localparam int RS = 3;
  localparam int PS = 1;
  localparam int LI = 2;
  localparam int NP = 2;
  localparam int DW = 2;
  localparam int LW = 2;
  localparam int SW = 2;
  localparam int WW = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            hold = 1'b0;
  logic [NP*DW-1:0] player_pos = '0;
  state_t          state;
  logic [SW-1:0]   seconds_left;
  logic            time_up;
  logic [DW-1:0]   correct_door;
  logic [NP*LW-1:0] lives;
  logic [NP-1:0]   alive;
  logic [7:0]      round_count;
  logic            game_over;
  logic [WW-1:0]   winner;
  logic            winner_valid;

  round_controller #(
    .NUM_PLAYERS(NP), .NUM_DOORS(4), .LIVES_INIT(LI), .TICKS_PER_SEC(T),
    .ROUND_SECS(RS), .PAUSE_SECS(PS), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .player_pos(player_pos),
    .state(state), .seconds_left(seconds_left), .time_up(time_up),
    .correct_door(correct_door), .lives(lives), .alive(alive),
    .round_count(round_count), .game_over(game_over), .winner(winner),
    .winner_valid(winner_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase plus remaining cycles in the phase
  state_t     m_st;
  int         m_cl;
  logic [1:0] m_door;
  int         m_lv[NP];
  int         m_rc;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic int n_alive();
    int n = 0;
    for (int i = 0; i < NP; i++) if (m_lv[i] > 0) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_st = IDLE; m_cl = 0; m_door = '0; m_rc = 0; m_lfsr = 8'hA5;
    for (int i = 0; i < NP; i++) m_lv[i] = LI;
  endtask

  task automatic model_step();
    logic [7:0] cur;
    cur = m_lfsr;
    m_lfsr = lfsr_step(m_lfsr);
    case (m_st)
      IDLE, GAME_OVER:
        if (start) begin
          for (int i = 0; i < NP; i++) m_lv[i] = LI;
          m_rc = 0; m_st = PLAY; m_cl = RS * T; m_door = cur[1:0];
        end
      PLAY:
        if (!hold) begin
          if (m_cl == 1) m_st = JUDGE; else m_cl--;
        end
      JUDGE: begin
        for (int i = 0; i < NP; i++)
          if (m_lv[i] > 0 && player_pos[i*DW +: DW] != m_door) m_lv[i]--;
        m_rc = (m_rc < 255) ? m_rc + 1 : 255;
        m_st = PAUSE; m_cl = PS * T;
      end
      PAUSE:
        if (!hold) begin
          if (m_cl == 1) begin
            if (n_alive() >= 2) begin
              m_st = PLAY; m_cl = RS * T; m_door = cur[1:0];
            end else m_st = GAME_OVER;
          end else m_cl--;
        end
      default: m_st = IDLE;
    endcase
  endtask

  task automatic check_model(input string tag);
    logic [NP-1:0]    ea;
    logic [NP*LW-1:0] el;
    logic [SW-1:0]    es;
    logic [WW-1:0]    ew;
    logic             ewv, etu, ego;
    int na;
    na = n_alive();
    ew = '0;
    for (int i = 0; i < NP; i++) begin
      ea[i] = (m_lv[i] != 0);
      el[i*LW +: LW] = LW'(m_lv[i]);
    end
    ewv = (m_st == GAME_OVER) && (na == 1);
    if (ewv) for (int i = 0; i < NP; i++) if (ea[i]) ew = WW'(i);
    es  = (m_st == PLAY || m_st == PAUSE) ? SW'((m_cl + T - 1) / T) : '0;
    etu = (m_st == JUDGE || m_st == PAUSE);
    ego = (m_st == GAME_OVER);
    vectors++;
    if (state !== m_st || seconds_left !== es || time_up !== etu ||
        correct_door !== m_door || lives !== el || alive !== ea ||
        round_count !== 8'(m_rc) || game_over !== ego || winner !== ew ||
        winner_valid !== ewv) begin
      miscompares++;
      $display("FAIL model/%s t=%0t: got st=%0d s=%0d tu=%0b door=%0d lives=%h alive=%b rc=%0d go=%0b w=%0d wv=%0b; want st=%0d s=%0d tu=%0b door=%0d lives=%h alive=%b rc=%0d go=%0b w=%0d wv=%0b",
        tag, $time, state, seconds_left, time_up, correct_door, lives, alive, round_count,
        game_over, winner, winner_valid, m_st, es, etu, m_door, el, ea, m_rc, ego, ew, ewv);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic set_pos(input bit hit0, input bit hit1);
    logic [1:0] p0, p1;
    p0 = hit0 ? m_door : m_door + 2'd1;
    p1 = hit1 ? m_door : m_door + 2'd1;
    player_pos = {p1, p0};
  endtask

  typedef struct {
    bit     start;
    bit     hit0;
    bit     hit1;
    int     ncyc;
    state_t st;
    int     secs;
    int     l0;
    int     l1;
    int     rc;
    bit     wv;
  } vec_t;

  vec_t tab[19];

  task automatic check_tab(input int k, input vec_t v);
    vectors++;
    if (state !== v.st || seconds_left !== SW'(v.secs) || lives[LW-1:0] !== LW'(v.l0) ||
        lives[2*LW-1:LW] !== LW'(v.l1) || round_count !== 8'(v.rc) || winner_valid !== v.wv) begin
      miscompares++;
      $display("FAIL tab[%0d]: got st=%0d s=%0d l0=%0d l1=%0d rc=%0d wv=%0b; want st=%0d s=%0d l0=%0d l1=%0d rc=%0d wv=%0b",
        k, state, seconds_left, lives[LW-1:0], lives[2*LW-1:LW], round_count, winner_valid,
        v.st, v.secs, v.l0, v.l1, v.rc, v.wv);
    end
  endtask

  initial begin
    int cnt;
    // start hit0 hit1 ncyc state secs l0 l1 rc wv
    tab[0]  = '{1, 1, 0,  1, PLAY,      3, 2, 2, 0, 0};
    tab[1]  = '{1, 1, 0,  4, PLAY,      2, 2, 2, 0, 0};
    tab[2]  = '{0, 1, 0,  4, PLAY,      1, 2, 2, 0, 0};
    tab[3]  = '{0, 1, 0,  3, PLAY,      1, 2, 2, 0, 0};
    tab[4]  = '{0, 1, 0,  1, JUDGE,     0, 2, 2, 0, 0};
    tab[5]  = '{0, 1, 0,  1, PAUSE,     1, 2, 1, 1, 0};
    tab[6]  = '{0, 1, 0,  3, PAUSE,     1, 2, 1, 1, 0};
    tab[7]  = '{0, 1, 0,  1, PLAY,      3, 2, 1, 1, 0};
    tab[8]  = '{0, 1, 0, 12, JUDGE,     0, 2, 1, 1, 0};
    tab[9]  = '{0, 1, 0,  1, PAUSE,     1, 2, 0, 2, 0};
    tab[10] = '{0, 1, 0,  4, GAME_OVER, 0, 2, 0, 2, 1};
    tab[11] = '{1, 0, 0,  1, PLAY,      3, 2, 2, 0, 0};
    tab[12] = '{0, 0, 0, 12, JUDGE,     0, 2, 2, 0, 0};
    tab[13] = '{0, 0, 0,  1, PAUSE,     1, 1, 1, 1, 0};
    tab[14] = '{0, 0, 0,  4, PLAY,      3, 1, 1, 1, 0};
    tab[15] = '{0, 0, 0, 12, JUDGE,     0, 1, 1, 1, 0};
    tab[16] = '{0, 0, 0,  1, PAUSE,     1, 0, 0, 2, 0};
    tab[17] = '{0, 0, 0,  4, GAME_OVER, 0, 0, 0, 2, 0};
    tab[18] = '{0, 0, 0,  3, GAME_OVER, 0, 0, 0, 2, 0};

    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_model("reset");
    check_val("reset_state", int'(state), int'(IDLE));
    check_val("reset_lives", int'(lives), 'hA);
    check_val("reset_alive", int'(alive), 3);
    check_val("reset_door", int'(correct_door), 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tab[k]) begin
      for (int c = 0; c < tab[k].ncyc; c++) begin
        start = tab[k].start;
        set_pos(tab[k].hit0, tab[k].hit1);
        tick($sformatf("tab%0d", k));
      end
      check_tab(k, tab[k]);
    end
    check_val("p1_win_idx", int'(winner), 1'b0);

    // hold mid-PLAY plus a late player_pos flip
    start = 1'b1;
    set_pos(0, 1);
    tick("hold_start");
    start = 1'b0;
    cnt = 0;
    repeat (5) begin tick("hold_pre"); cnt++; end
    hold = 1'b1;
    repeat (5) begin
      tick("hold_on"); cnt++;
      check_val("hold_secs_frozen", int'(seconds_left), 2);
    end
    hold = 1'b0;
    while (state != JUDGE && cnt < 40) begin
      set_pos(0, 1);
      start = 1'b1;
      tick("hold_post"); cnt++;
    end
    start = 1'b0;
    check_val("hold_play_len", cnt, RS * T + 5);
    set_pos(1, 0);
    tick("judge_sample");
    check_val("late_pos_l0", int'(lives[LW-1:0]), 2);
    check_val("late_pos_l1", int'(lives[2*LW-1:LW]), 1);

    // async reset mid-PAUSE
    tick("pause2");
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_model("mid_reset");
    check_val("mid_reset_state", int'(state), int'(IDLE));
    check_val("mid_reset_rc", int'(round_count), 0);
    check_val("mid_reset_tu", int'(time_up), 0);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    tick("restart");
    start = 1'b0;
    check_val("restart_lives", int'(lives), 'hA);
    check_val("restart_rc", int'(round_count), 0);

    // randomized run
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(599, 0) == 0) begin
        #2 reset = 1'b0;
        model_reset();
        #1 check_model("rand_reset");
        @(negedge clk);
        reset = 1'b1;
      end
      start      = ($urandom_range(7, 0) == 0);
      hold       = ($urandom_range(4, 0) == 0);
      player_pos = NP*DW'($urandom);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/round_controller.md
# round_controller

Parametrised game-round sequencer for the door-guessing game: runs a timed play phase, judges every player's door choice against a pseudo-randomly chosen correct door, deducts lives, holds a timed pause, and repeats until at most one player is alive. It sits between the switch/input logic and the screen drawer and seven-segment timer. It replaces the hand-wired time_up/resume counter pair and fixed door/lives registers with a generalised N-player block.

## Interface
- NUM_PLAYERS, 2, players tracked (≥2)
- NUM_DOORS, 4, doors per round; power of two, ≥2; DOOR_W = $clog2(NUM_DOORS)
- LIVES_INIT, 3, lives per player at game start (≥1); LIFE_W = $clog2(LIVES_INIT+1)
- TICKS_PER_SEC, 25_000_000, clk cycles per second
- ROUND_SECS, 10, play-phase length in seconds (≥1)
- PAUSE_SECS, 1, pause-phase length in seconds (≥1); SEC_W = $clog2(max(ROUND_SECS,PAUSE_SECS)+1)
- LFSR_SEED, 8'hA5, non-zero 8-bit LFSR reset value

Ports:
- clk  in  1  pixel clock (the VGA_CLK domain)
- reset  in  1  asynchronous, active-low reset
- start  in  1  level; begins a game from IDLE or GAME_OVER
- hold  in  1  freezes prescaler and second counter while high
- player_pos  in  NUM_PLAYERS*DOOR_W  door selected by player i in bits [i*DOOR_W +: DOOR_W]
- state  out  3  current round_pkg::state_t
- seconds_left  out  SEC_W  seconds remaining in the current phase
- time_up  out  1  high in JUDGE and PAUSE
- correct_door  out  DOOR_W  door latched for the current round
- lives  out  NUM_PLAYERS*LIFE_W  lives of player i in bits [i*LIFE_W +: LIFE_W]
- alive  out  NUM_PLAYERS  bit i = lives of player i non-zero
- round_count  out  8  rounds judged this game, saturates at 255
- game_over  out  1  high in GAME_OVER
- winner  out  max(1,$clog2(NUM_PLAYERS))  index of the sole survivor
- winner_valid  out  1  high in GAME_OVER when exactly one player is alive

## Operation
- States: IDLE, PLAY, JUDGE, PAUSE, GAME_OVER.
- IDLE: start=1 leads to PLAY entry.
- PLAY entry, also used for new rounds: clear the prescaler, set seconds_left=ROUND_SECS, and latch correct_door = lfsr[DOOR_W-1:0].
- Game start is IDLE/GAME_OVER → PLAY. It also sets all lives to LIVES_INIT and round_count to 0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances every clk, including during hold, and is never zero.
- sec_tick: pulses when the prescaler reaches TICKS_PER_SEC-1 while hold=0. The prescaler then wraps to 0.
- PLAY: each sec_tick decrements seconds_left. A sec_tick with seconds_left==1 sets seconds_left=0 and goes to JUDGE.
- JUDGE (exactly 1 cycle): for each alive player with pos ≠ correct_door, lives decrements by 1, saturating at 0. round_count increments. Then PAUSE with seconds_left=PAUSE_SECS and prescaler cleared.
- player_pos is sampled only in the JUDGE cycle. Dead players are ignored.
- PAUSE: counts down the same way. A sec_tick at 1 evaluates the alive count:
  - 0 or 1 alive → GAME_OVER.
  - 2 or more alive → PLAY entry (new door, round_count kept).
- GAME_OVER: lives and correct_door are frozen. If alive count is 1, winner_valid=1 and winner=that index; if 0, it is a draw with winner_valid=0 and winner=0. start=1 leads to game start.
- start is ignored in PLAY, JUDGE and PAUSE.

## Timing
- Reset values:
  - state=IDLE, seconds_left=0, time_up=0, correct_door=0.
  - lives all LIVES_INIT, alive all 1s, round_count=0.
  - game_over=0, winner=0, winner_valid=0, lfsr=LFSR_SEED, prescaler=0.
- All outputs are registered or decoded from registers. No combinational path from inputs to outputs.
- PLAY lasts exactly ROUND_SECS*TICKS_PER_SEC cycles with hold=0. PAUSE lasts PAUSE_SECS*TICKS_PER_SEC cycles.
- Each cycle with hold=1 extends the phase by one cycle. hold has no effect in JUDGE, IDLE or GAME_OVER.
- lives, alive and round_count update on the clock edge that leaves JUDGE. They are visible in the first PAUSE cycle.
- Reset asserted mid-phase returns to the reset values immediately (asynchronous). Nothing is retained.

## Structure
- round_pkg: state_t enum (3-bit), LFSR tap constant, and the width helper functions for SEC_W, LIFE_W and winner width.
- One sub-module, sec_tick_gen (parameters TICKS_PER_SEC; ports clk, reset, clear, hold, tick). The top holds the FSM, the LFSR, the lives array and the winner reduction.

## Test plan
Test parameters for all scenarios: TICKS_PER_SEC=4, ROUND_SECS=3, PAUSE_SECS=1, LIVES_INIT=2, NUM_PLAYERS=2.
1. Reset, start pulse → PLAY for 12 cycles with seconds_left 3,2,1 per 4 cycles → 1-cycle JUDGE with time_up=1 → PAUSE for 4 cycles → PLAY.
2. P0 on correct_door, P1 on another door → after JUDGE, lives={P0:2, P1:1}, round_count=1. Repeat the miss → P1 lives=0, alive=2'b01, GAME_OVER, winner=0, winner_valid=1.
3. Both players always wrong → both reach 0 in the same JUDGE → GAME_OVER, winner_valid=0.
4. hold=1 for 5 cycles mid-PLAY → JUDGE is delayed by exactly 5 cycles and seconds_left is frozen during hold.
5. player_pos changes in the cycle before JUDGE → only the JUDGE-cycle value counts. start held high during PLAY → no effect.
6. Reset pulsed low mid-PAUSE → all outputs return to their reset values. Restart → lives=2/2, round_count=0, and correct_door equals the LFSR low bits at PLAY entry.
